// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser plus per-bit stability filter with registered edge strobes
module switch_debouncer #(
  parameter int WIDTH = 18,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] sync1, sync2, done;
  logic [CNT_W-1:0] cnt [WIDTH];
  always_comb begin
    done = '0;
    for (int i = 0; i < WIDTH; i++) done[i] = (sync2[i] != sw_out[i]) && (cnt[i] == LAST);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sw_out <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      sw_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
      sw_out <= sw_out ^ done;
      sw_rise <= done & sync2;
      sw_fall <= done & ~sync2;
      sw_changed <= |done;
      // any return to the committed level, or a commit, restarts the count
      for (int i = 0; i < WIDTH; i++) cnt[i] <= (sync2[i] == sw_out[i] || done[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed vector table, hand sequences for bounce/reset corners, random run vs model
module tb_switch_debouncer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [17:0] sw_raw = '0;
  logic [17:0] sw_out, sw_rise, sw_fall;
  logic sw_changed;
  int passed = 0;
  int total = 0;

  switch_debouncer #(.WIDTH(18), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_out(sw_out),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  logic [17:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic m_chg;
  int m_run [18];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
    for (int i = 0; i < 18; i++) m_run[i] = 0;
  endtask

  // behavioural model: a bit commits once its synchronised value has differed for 4 consecutive edges
  task automatic model_edge(input logic [17:0] raw);
    logic [17:0] nout;
    nout = m_out; m_rise = '0; m_fall = '0;
    for (int i = 0; i < 18; i++) begin
      if (m_s2[i] != m_out[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == 4) begin
        nout[i] = m_s2[i];
        if (m_s2[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
        m_run[i] = 0;
      end
    end
    m_chg = |(m_rise | m_fall);
    m_out = nout;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic tick(input logic [17:0] raw);
    sw_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
  endtask

  task automatic chk(input string name, input logic [17:0] eo, input logic [17:0] er,
                     input logic [17:0] ef, input logic ec);
    total++;
    if (sw_out === eo && sw_rise === er && sw_fall === ef && sw_changed === ec) passed++;
    else $display("FAIL %s: got out=%h rise=%h fall=%h chg=%b, expected out=%h rise=%h fall=%h chg=%b",
                  name, sw_out, sw_rise, sw_fall, sw_changed, eo, er, ef, ec);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [17:0] raw;
    int n;
    logic [17:0] o, r, f;
    logic c;
  } vec_t;
  vec_t tbl [14];

  initial begin
    tbl[0]  = '{18'h3FFFF, 5, 18'h00000, 18'h00000, 18'h00000, 1'b0};
    tbl[1]  = '{18'h3FFFF, 1, 18'h3FFFF, 18'h3FFFF, 18'h00000, 1'b1};
    tbl[2]  = '{18'h3FFFF, 1, 18'h3FFFF, 18'h00000, 18'h00000, 1'b0};
    tbl[3]  = '{18'h3FFFE, 5, 18'h3FFFF, 18'h00000, 18'h00000, 1'b0};
    tbl[4]  = '{18'h3FFFE, 1, 18'h3FFFE, 18'h00000, 18'h00001, 1'b1};
    tbl[5]  = '{18'h3FFFE, 1, 18'h3FFFE, 18'h00000, 18'h00000, 1'b0};
    tbl[6]  = '{18'h3FFFF, 5, 18'h3FFFE, 18'h00000, 18'h00000, 1'b0};
    tbl[7]  = '{18'h3FFFF, 1, 18'h3FFFF, 18'h00001, 18'h00000, 1'b1};
    tbl[8]  = '{18'h3FFFF, 4, 18'h3FFFF, 18'h00000, 18'h00000, 1'b0};
    tbl[9]  = '{18'h1FFDF, 5, 18'h3FFFF, 18'h00000, 18'h00000, 1'b0};
    tbl[10] = '{18'h1FFDF, 1, 18'h1FFDF, 18'h00000, 18'h20020, 1'b1};
    tbl[11] = '{18'h1FFDF, 1, 18'h1FFDF, 18'h00000, 18'h00000, 1'b0};
    tbl[12] = '{18'h1FFD7, 6, 18'h1FFD7, 18'h00000, 18'h00008, 1'b1};
    tbl[13] = '{18'h1FFD7, 1, 18'h1FFD7, 18'h00000, 18'h00000, 1'b0};

    sw_raw = 18'h3FFFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 18'h0, 18'h0, 18'h0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      repeat (tbl[k].n) tick(tbl[k].raw);
      chk($sformatf("vec%0d", k), tbl[k].o, tbl[k].r, tbl[k].f, tbl[k].c);
    end

    for (int k = 0; k < 8; k++) begin
      tick(k[1] ? 18'h1FFD7 : 18'h1FFDF);
      chk($sformatf("bounce%0d", k), 18'h1FFD7, 18'h0, 18'h0, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      tick(18'h1FFDF);
      chk($sformatf("settle%0d", k), 18'h1FFD7, 18'h0, 18'h0, 1'b0);
    end
    tick(18'h1FFDF);
    chk("settle_rise", 18'h1FFDF, 18'h00008, 18'h0, 1'b1);
    tick(18'h1FFDF);
    chk("settle_after", 18'h1FFDF, 18'h0, 18'h0, 1'b0);

    sw_raw = 18'h0;
    do_reset(2);
    for (int k = 0; k < 4; k++) tick(18'h00080);
    chk("b7_precount", 18'h0, 18'h0, 18'h0, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_reset", 18'h0, 18'h0, 18'h0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      tick(18'h00080);
      chk($sformatf("b7_recount%0d", k), 18'h0, 18'h0, 18'h0, 1'b0);
    end
    tick(18'h00080);
    chk("b7_rise", 18'h00080, 18'h00080, 18'h0, 1'b1);
    tick(18'h00080);
    chk("b7_after", 18'h00080, 18'h0, 18'h0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      tick(k < 3 ? 18'h0 : 18'h00080);
      chk($sformatf("short_pulse%0d", k), 18'h00080, 18'h0, 18'h0, 1'b0);
    end

    do_reset(2);
    begin
      logic [17:0] r;
      r = '0;
      for (int k = 0; k < 600; k++) begin
        if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 17)] ^= 1'b1;
        if ($urandom_range(0, 29) == 0) r = 18'($urandom);
        tick(r);
        chk($sformatf("rand%0d", k), m_out, m_rise, m_fall, m_chg);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
